// File: rtl/abc.sv
// abc: I/O bus master that polls port A, reads a byte A, and writes A*5 to B_out
// high byte first. Define ABC_BUS_WAIT_EN to stretch strobes to 3 cycles (5-cycle access).
module abc (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] addr,
    inout  wire  [7:0]  data,
    output logic        ior_,
    output logic        iow_
);

`ifdef ABC_BUS_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_POLL, S_RDA, S_CALC, S_WRH, S_WRL} state_t;
    typedef enum logic [2:0] {PH_IDLE, PH_T1, PH_T2, PH_T3, PH_T3W, PH_T4} phase_t;

    state_t      state_q;
    phase_t      phase_q;
    logic [15:0] addr_q;
    logic        ior_q;
    logic        iow_q;
    logic        oe_q;
    logic [7:0]  dout_q;
    logic [7:0]  a_q;
    logic [15:0] p_q;
    logic        fi_q;

    state_t      nxt_state;
    state_t      start_st;
    logic [15:0] p_d;
    logic [15:0] p_use;
    logic [15:0] start_addr;
    logic [7:0]  start_byte;
    logic        start_wr;
    logic        cur_wr;
    logic        begin_acc;

    assign addr = addr_q;
    assign ior_ = ior_q;
    assign iow_ = iow_q;
    assign data = oe_q ? dout_q : 'z;

    always_comb begin
        p_d = {6'b0, a_q, 2'b00} + {8'b0, a_q};

        nxt_state = S_POLL;
        case (state_q)
            S_POLL:  nxt_state = fi_q ? S_RDA : S_POLL;
            S_RDA:   nxt_state = S_CALC;
            S_CALC:  nxt_state = S_WRH;
            S_WRH:   nxt_state = S_WRL;
            default: nxt_state = S_POLL;
        endcase

        // CALC is entered as an idle phase; its exit launches WRH with the fresh product.
        begin_acc = (phase_q == PH_IDLE) || ((phase_q == PH_T4) && (nxt_state != S_CALC));
        start_st  = (phase_q == PH_IDLE) ? ((state_q == S_CALC) ? S_WRH : state_q) : nxt_state;
        p_use     = (state_q == S_CALC) ? p_d : p_q;
        start_wr  = (start_st == S_WRH) || (start_st == S_WRL);
        start_byte = (start_st == S_WRL) ? p_use[7:0] : p_use[15:8];

        start_addr = 16'h0121;
        case (start_st)
            S_POLL:  start_addr = 16'h0100;
            S_RDA:   start_addr = 16'h0101;
            default: start_addr = 16'h0121;
        endcase

        cur_wr = (state_q == S_WRH) || (state_q == S_WRL);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_POLL;
            phase_q <= PH_IDLE;
            addr_q  <= '0;
            ior_q   <= 1'b1;
            iow_q   <= 1'b1;
            oe_q    <= 1'b0;
            dout_q  <= '0;
            a_q     <= '0;
            p_q     <= '0;
            fi_q    <= 1'b0;
        end else if (begin_acc) begin
            if (state_q == S_CALC) begin
                p_q <= p_d;
            end
            state_q <= start_st;
            phase_q <= PH_T1;
            addr_q  <= start_addr;
            oe_q    <= start_wr;
            dout_q  <= start_byte;
        end else begin
            case (phase_q)
                PH_T1: begin
                    phase_q <= PH_T2;
                    ior_q   <= cur_wr;
                    iow_q   <= !cur_wr;
                end
                PH_T2: phase_q <= PH_T3;
                PH_T3, PH_T3W: begin
                    if (WAIT_EN && (phase_q == PH_T3)) begin
                        phase_q <= PH_T3W;
                    end else begin
                        phase_q <= PH_T4;
                        ior_q   <= 1'b1;
                        iow_q   <= 1'b1;
                        if (state_q == S_POLL) fi_q <= data[0];
                        if (state_q == S_RDA)  a_q  <= data;
                    end
                end
                PH_T4: begin
                    state_q <= S_CALC;
                    phase_q <= PH_IDLE;
                    oe_q    <= 1'b0;
                end
                default: phase_q <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_abc.sv
// tb_abc: drives a port-A device model and checks abc against a transaction-level
// model of the expected bus cycles, plus literal pins on the written bytes.
module tb_abc;

`ifdef ABC_BUS_WAIT_EN
    localparam int unsigned ACC_LEN = 5;
`else
    localparam int unsigned ACC_LEN = 4;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr;
    logic        ior_;
    logic        iow_;
    wire  [7:0]  data;

    abc dut (
        .clock (clock),
        .reset (reset),
        .addr  (addr),
        .data  (data),
        .ior_  (ior_),
        .iow_  (iow_)
    );

    always #5 clock = ~clock;

    // Port-A device: bytes become ready after a delay counted from when they reach the head.
    typedef struct {
        logic [7:0]  b;
        int unsigned delay;
    } item_t;

    item_t       items[$];
    logic        dev_fi   = 1'b0;
    logic [7:0]  dev_byte = 8'h00;
    bit          armed    = 1'b0;
    int unsigned ready_at = 0;
    int unsigned cyc_n    = 0;
    logic [7:0]  dev_rd;

    always_comb begin
        dev_rd = 8'h00;
        if (addr == 16'h0100)      dev_rd = {7'b0, dev_fi};
        else if (addr == 16'h0101) dev_rd = dev_byte;
    end

    assign data = ior_ ? 8'hzz : dev_rd;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (data[g]);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected completion at %0t", name, $time);
    endtask

    // Expected bus activity as a queue of accesses (a 1-cycle idle entry models CALC).
    typedef struct {
        logic [15:0] addr;
        bit          rd;
        bit          wr;
        logic [7:0]  wdata;
        int unsigned len;
    } acc_t;

    function automatic acc_t mk(input logic [15:0] a, input bit rd, input bit wr,
                                input logic [7:0] w, input int unsigned len);
        acc_t r;
        r.addr = a; r.rd = rd; r.wr = wr; r.wdata = w; r.len = len;
        return r;
    endfunction

    acc_t        mq[$];
    int unsigned mcyc = 0;
    bit          fi_seen = 1'b0;
    logic [7:0]  byte_seen = 8'h00;

    bit          prev_low = 1'b0;
    logic        prev_ior = 1'b1;
    logic [15:0] prev_addr = 16'h0000;
    int unsigned hi_run = 0;
    logic [7:0]  wlog[$];
    int unsigned rd101_cnt = 0;
    int unsigned other_cnt = 0;
    bit          want_first = 1'b0;
    logic [15:0] first_addr = 16'h0000;
    bit          first_rd = 1'b0;

    always @(negedge clock) begin
        acc_t        a;
        bit          on;
        int unsigned p;

        cyc_n++;
        if (!reset && !prev_ior && ior_ && (addr == 16'h0101)) begin
            dev_fi = 1'b0;
            armed  = 1'b0;
            if (items.size() > 0) items.delete(0);
        end
        if (!armed && (items.size() > 0)) begin
            ready_at = cyc_n + items[0].delay;
            armed    = 1'b1;
        end
        if (armed && !dev_fi && (cyc_n >= ready_at)) begin
            dev_fi   = 1'b1;
            dev_byte = items[0].b;
        end

        if (reset) begin
            chk("rst_addr", 32'(addr), 32'h0000);
            chk("rst_ior_", 32'(ior_), 32'd1);
            chk("rst_iow_", 32'(iow_), 32'd1);
            chk("rst_data_released", 32'(data), 32'hFF);
            mq.delete();
            mq.push_back(mk(16'h0100, 1'b1, 1'b0, 8'h00, ACC_LEN));
            mcyc       = 0;
            prev_low   = 1'b0;
            prev_ior   = 1'b1;
            hi_run++;
            want_first = 1'b1;
        end else begin
            if (mq.size() == 0) mq.push_back(mk(16'h0100, 1'b1, 1'b0, 8'h00, ACC_LEN));
            a  = mq[0];
            on = (mcyc >= 1) && (mcyc + 2 <= a.len);
            chk("addr", 32'(addr), 32'(a.addr));
            chk("ior_", 32'(ior_), 32'(!(a.rd && on)));
            chk("iow_", 32'(iow_), 32'(!(a.wr && on)));
            if (a.wr)            chk("wdata", 32'(data), 32'(a.wdata));
            else if (a.rd && on) chk("rdata_bus", 32'(data), 32'(dev_rd));
            else                 chk("data_released", 32'(data), 32'hFF);
            if (a.rd && (mcyc + 2 == a.len)) begin
                fi_seen   = dev_fi;
                byte_seen = dev_byte;
            end
            mcyc++;
            if (mcyc == a.len) begin
                mq.delete(0);
                mcyc = 0;
                if (a.rd && (a.addr == 16'h0100)) begin
                    mq.push_back(mk(fi_seen ? 16'h0101 : 16'h0100, 1'b1, 1'b0, 8'h00, ACC_LEN));
                end else if (a.rd && (a.addr == 16'h0101)) begin
                    p = 32'(byte_seen) * 5;
                    mq.push_back(mk(16'h0101, 1'b0, 1'b0, 8'h00, 1));
                    mq.push_back(mk(16'h0121, 1'b0, 1'b1, 8'(p >> 8), ACC_LEN));
                    mq.push_back(mk(16'h0121, 1'b0, 1'b1, 8'(p & 32'hFF), ACC_LEN));
                    mq.push_back(mk(16'h0100, 1'b1, 1'b0, 8'h00, ACC_LEN));
                end
            end

            if (!ior_ || !iow_) begin
                chk("strobe_excl", 32'(ior_ | iow_), 32'd1);
                if (prev_low) begin
                    chk("addr_hold", 32'(addr), 32'(prev_addr));
                end else begin
                    chk("strobe_gap", 32'(hi_run >= 2), 32'd1);
                    if (want_first) begin
                        first_addr = addr;
                        first_rd   = !ior_;
                        want_first = 1'b0;
                    end
                    if (!ior_ && (addr == 16'h0101)) begin
                        rd101_cnt++;
                        chk("rd101_when_ready", 32'(dev_fi), 32'd1);
                    end else if (!iow_ && (addr == 16'h0121)) begin
                        wlog.push_back(data);
                    end else if (!(!ior_ && (addr == 16'h0100))) begin
                        other_cnt++;
                    end
                end
                prev_low = 1'b1;
                hi_run   = 0;
            end else begin
                prev_low = 1'b0;
                hi_run++;
            end
            prev_addr = addr;
            prev_ior  = ior_;
        end
    end

    initial begin
        int unsigned t;
        int unsigned pv;
        item_t       it;

        it.b = 8'h05; it.delay = 240; items.push_back(it);
        it.b = 8'hFF; it.delay = 10;  items.push_back(it);
        for (int i = 0; i < 30; i++) begin
            it.b = 8'((i * i + 5) % 256); it.delay = 240;
            items.push_back(it);
        end

        repeat (3) @(negedge clock);
        #2 reset = 1'b0;

        t = 0;
        while (!((items.size() == 0) && (wlog.size() >= 64)) && (t < 20000)) begin
            @(negedge clock);
            t++;
        end
        if (t >= 20000) expire("items_done");
        repeat (2) @(negedge clock);

        chk("write_count", 32'(wlog.size()), 32'd64);
        chk("rd101_count", 32'(rd101_cnt), 32'd32);
        chk("stray_access", 32'(other_cnt), 32'd0);
        if (wlog.size() >= 64) begin
            chk("a05_hi", 32'(wlog[0]), 32'h00);
            chk("a05_lo", 32'(wlog[1]), 32'h19);
            chk("aff_hi", 32'(wlog[2]), 32'h04);
            chk("aff_lo", 32'(wlog[3]), 32'hFB);
            for (int i = 0; i < 30; i++) begin
                pv = 32'((i * i + 5) % 256) * 5;
                chk("item_hi", 32'(wlog[4 + 2 * i]), pv >> 8);
                chk("item_lo", 32'(wlog[5 + 2 * i]), pv & 32'hFF);
            end
        end

        it.b = 8'h33; it.delay = 5; items.push_back(it);
        t = 0;
        while ((iow_ !== 1'b0) && (t < 2000)) begin
            @(negedge clock);
            t++;
        end
        if (t >= 2000) expire("wait_write");
        #2 reset = 1'b1;
        #1;
        chk("midwr_iow_", 32'(iow_), 32'd1);
        chk("midwr_ior_", 32'(ior_), 32'd1);
        chk("midwr_addr", 32'(addr), 32'h0000);
        chk("midwr_data", 32'(data), 32'hFF);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;

        it.b = 8'h07; it.delay = 20; items.push_back(it);
        t = 0;
        while (!((items.size() == 0) && (wlog.size() >= 67)) && (t < 2000)) begin
            @(negedge clock);
            t++;
        end
        if (t >= 2000) expire("post_reset_item");
        repeat (2) @(negedge clock);

        chk("first_addr_after_rst", 32'(first_addr), 32'h0100);
        chk("first_is_read", 32'(first_rd), 32'd1);
        chk("write_count_end", 32'(wlog.size()), 32'd67);
        chk("stray_access_end", 32'(other_cnt), 32'd0);
        if (wlog.size() >= 67) begin
            chk("a33_hi", 32'(wlog[64]), 32'h00);
            chk("a07_hi", 32'(wlog[65]), 32'h00);
            chk("a07_lo", 32'(wlog[66]), 32'h23);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/abc.md
# abc

Bus-master controller on the 8-bit I/O bus, 16-bit address space. It polls a handshake input port A until a byte is ready and reads that byte. It computes A×5 as a 16-bit value and writes it to output port B_out as two bytes, high byte first, then repeats forever. It is the only master on the bus and must never touch any address other than the ones listed below.

## Interface
- Parameters: none.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  out  16  I/O address.
- `data`  inout  8  bidirectional I/O data bus.
  - Driven only during write accesses.
  - High-impedance otherwise, including during reset.
- `ior_`  out  1  read strobe, active low.
- `iow_`  out  1  write strobe, active low.

## Operation
Address map:
- 0x0100: A status; bit0 = FI (data ready).
- 0x0101: A data; reading it consumes the byte and clears FI.
- 0x0120: B_in (read-only byte). Not accessed in this block.
- 0x0121: B_out (write-only byte).

State sequence, one bus access per state:
- POLL: read 0x0100.
  - FI=0: repeat POLL.
  - FI=1: go to RDA.
- RDA: read 0x0101 into 8-bit register A.
- CALC: one internal cycle, no bus access. P = {A,2'b00} + {2'b00,A}, zero-extended to 16 bits; maximum 255×5 = 1275.
- WRH: write P[15:8] to 0x0121.
- WRL: write P[7:0] to 0x0121, then return to POLL.

Bus and reset rules:
- A data (0x0101) is never read unless the immediately preceding status read returned FI=1.
- Reset (any time, including mid-access) has immediate effect:
  - `ior_`=1, `iow_`=1.
  - `addr`=0x0000, `data` released (Z).
  - A=0, P=0, state=POLL.
- A bus access interrupted by reset is abandoned and not retried.

## Timing
Every bus access is 4 clock cycles, T1–T4:
- T1: `addr` driven to the target. Strobes high. For a write, `data` driven with the write byte.
- T2, T3: the selected strobe is low.
  - Read: `data` sampled on the rising edge that ends T3.
  - Write: `data` held.
- T4: strobe high. `addr` and write `data` still held.
- After T4, `data` is released for reads. `addr` holds its last value until the next T1.

Rules:
- `addr` never changes while a strobe is low.
- `ior_` and `iow_` are never low simultaneously.
- A strobe is always high for at least 2 consecutive cycles between accesses (T4 plus next T1), so devices with slow decode/release (up to 4 ns at a 10 ns clock) see clean, separated accesses.
- Per item, without the wait option: n polls ×4, + RDA 4, + CALC 1, + WRH 4, + WRL 4 cycles.
- Strobes and `addr` come from registers (glitch-free).

## Configuration
- `ABC_BUS_WAIT_EN` defined: strobes stay low 3 cycles (T2, T3, T3w); read sampling occurs at the end of T3w. Each access is then 5 cycles. All other behaviour is unchanged.
- Undefined: 4-cycle accesses as above.

## Test plan
- Reset asserted mid-write (`iow_` low) → `iow_`=1, `ior_`=1, `addr`=0x0000 and `data`=Z within the same time step; after release, the first access is a read of 0x0100.
- FI held 0 for 240 cycles → only reads of 0x0100 occur; no access to 0x0101 or 0x0121; `data` never driven by the DUT.
- FI=1 with A=0x05 → read 0x0101, then writes 0x00 then 0x19 to 0x0121 (P=25).
- A=0xFF → writes 0x04 then 0xFB (P=1275).
- 30 items with A=(i·i+5) mod 256, i=0..29, each becoming ready after 240 cycles:
  - every byte pair equals A×5;
  - no access outside 0x0100/0x0101/0x0121;
  - no 0x0101 read while FI=0.
- Strobe check: `addr` stable whenever either strobe is low; strobes never low together; at least 2 high cycles between accesses.
